// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding and mode constants for the multi-channel tick counter
package cnt_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/cnt_chan.sv
// cnt_chan: one timer channel with FSM, programmable terminal count, done strobes and sticky status
module cnt_chan
  import cnt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_out,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         en,
  input  logic         pause,
  input  logic         mode,
  input  logic [W-1:0] limit,
  input  logic         sts_clr,
  output logic [W-1:0] cnt,
  output logic         done_pulse,
  output logic         done_lvl,
  output logic         sts
);
  state_t       state;
  logic [W-1:0] lim_q;
  logic         mode_q;
  // channel FSM: disable wins, IDLE captures config, RUN counts qualifying ticks, HOLD parks at terminal
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lim_q      <= '0;
      mode_q     <= MODE_ONESHOT;
      done_pulse <= 1'b0;
      done_lvl   <= 1'b0;
    end else if (!en) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      done_pulse <= 1'b0;
      done_lvl   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          lim_q  <= limit;
          mode_q <= mode;
          cnt    <= '0;
          if (limit != '0) state <= ST_RUN;
        end
        ST_RUN: begin
          if (tick && !pause) begin
            if (cnt == lim_q - W'(1)) begin
              done_pulse <= 1'b1;
              if (mode_q == MODE_PERIODIC) begin
                cnt <= '0;
              end else begin
                cnt      <= lim_q;
                done_lvl <= 1'b1;
                state    <= ST_HOLD;
              end
            end else begin
              cnt <= cnt + W'(1);
            end
          end
        end
        ST_HOLD: done_lvl <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end
  // sticky status: a registered pulse sets it one edge later, and setting beats clearing
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) sts <= 1'b0;
    else        sts <= (sts & ~sts_clr) | done_pulse;
  end
endmodule

// File: rtl/cnt_timer_mc.sv
// cnt_timer_mc: CH independent tick-driven timer channels sharing one tick, with masked irq
module cnt_timer_mc
  import cnt_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] pause,
  input  logic [CH-1:0] mode,
  input  logic [CH*W-1:0] limit,
  input  logic [CH-1:0] sts_clr,
  input  logic [CH-1:0] irq_mask,
  output logic [CH*W-1:0] cnt,
  output logic [CH-1:0] done_pulse,
  output logic [CH-1:0] done_lvl,
  output logic [CH-1:0] sts,
  output logic          irq
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    cnt_chan #(.W(W)) u_chan (
      .clk_out    (clk_out),
      .rst_n      (rst_n),
      .tick       (tick),
      .en         (en[i]),
      .pause      (pause[i]),
      .mode       (mode[i]),
      .limit      (limit[i*W +: W]),
      .sts_clr    (sts_clr[i]),
      .cnt        (cnt[i*W +: W]),
      .done_pulse (done_pulse[i]),
      .done_lvl   (done_lvl[i]),
      .sts        (sts[i])
    );
  end
  assign irq = |(sts & irq_mask);
endmodule

// File: tb/tb_cnt_timer_mc.sv
// tb_cnt_timer_mc: randomized stimulus checked against a tick-counting reference model
module tb_cnt_timer_mc;
  localparam int CH = 4;
  localparam int W  = 8;
  logic            clk_out = 1'b0;
  logic            rst_n;
  logic            tick;
  logic [CH-1:0]   en, pause, mode, sts_clr, irq_mask;
  logic [CH*W-1:0] limit;
  logic [CH*W-1:0] cnt;
  logic [CH-1:0]   done_pulse, done_lvl, sts;
  logic            irq;
  int checks = 0;
  int errors = 0;
  // model: per channel, whether it is armed, its captured limit/mode, and qualifying ticks seen
  bit armed [CH];
  int lim_m [CH];
  bit per_m [CH];
  int q_m   [CH];
  bit pul_m [CH];
  bit sts_m [CH];
  cnt_timer_mc #(.CH(CH), .W(W)) dut (
    .clk_out    (clk_out),
    .rst_n      (rst_n),
    .tick       (tick),
    .en         (en),
    .pause      (pause),
    .mode       (mode),
    .limit      (limit),
    .sts_clr    (sts_clr),
    .irq_mask   (irq_mask),
    .cnt        (cnt),
    .done_pulse (done_pulse),
    .done_lvl   (done_lvl),
    .sts        (sts),
    .irq        (irq)
  );
  always #5 clk_out = ~clk_out;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      armed[i] = 0; lim_m[i] = 0; per_m[i] = 0; q_m[i] = 0; pul_m[i] = 0; sts_m[i] = 0;
    end
  endfunction
  function automatic void model_step();
    for (int i = 0; i < CH; i++) begin
      int lim_in;
      lim_in   = int'(limit[i*W +: W]);
      sts_m[i] = (sts_m[i] & !sts_clr[i]) | pul_m[i];
      pul_m[i] = 0;
      if (!en[i]) begin
        armed[i] = 0; q_m[i] = 0;
      end else if (!armed[i]) begin
        lim_m[i] = lim_in; per_m[i] = mode[i]; q_m[i] = 0;
        armed[i] = (lim_in != 0);
      end else if (!(!per_m[i] && q_m[i] == lim_m[i]) && tick && !pause[i]) begin
        q_m[i]++;
        if (q_m[i] == lim_m[i]) begin
          pul_m[i] = 1;
          if (per_m[i]) q_m[i] = 0;
        end
      end
    end
  endfunction
  task automatic compare_all();
    int irq_e;
    irq_e = 0;
    for (int i = 0; i < CH; i++) begin
      bit lvl;
      lvl = armed[i] && !per_m[i] && q_m[i] == lim_m[i];
      chk($sformatf("cnt%0d", i), int'(cnt[i*W +: W]), q_m[i]);
      chk($sformatf("done_pulse%0d", i), int'(done_pulse[i]), int'(pul_m[i]));
      chk($sformatf("done_lvl%0d", i), int'(done_lvl[i]), int'(lvl));
      chk($sformatf("sts%0d", i), int'(sts[i]), int'(sts_m[i]));
      if (sts_m[i] && irq_mask[i]) irq_e = 1;
    end
    chk("irq", int'(irq), irq_e);
  endtask
  task automatic drive_random();
    tick = ($urandom_range(0, 2) != 0);
    for (int i = 0; i < CH; i++) begin
      if (!en[i]) en[i] = ($urandom_range(0, 3) == 0);
      else        en[i] = ($urandom_range(0, 40) != 0);
      pause[i]    = ($urandom_range(0, 4) == 0);
      sts_clr[i]  = ($urandom_range(0, 5) == 0);
      irq_mask[i] = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) begin
        mode[i] = $urandom_range(0, 1);
        case ($urandom_range(0, 15))
          0:       limit[i*W +: W] = 8'd255;
          1:       limit[i*W +: W] = 8'd0;
          2:       limit[i*W +: W] = 8'd1;
          default: limit[i*W +: W] = W'($urandom_range(2, 10));
        endcase
      end
    end
  endtask
  initial begin
    rst_n = 1'b0; tick = 1'b0; en = '0; pause = '0; mode = '0;
    limit = '0; sts_clr = '0; irq_mask = '1;
    model_reset();
    repeat (2) @(negedge clk_out);
    compare_all();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk_out);
      compare_all();
      if (cyc == 3000) begin
        rst_n = 1'b0;
        #1;
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_pulse", int'(done_pulse), 0);
        chk("rst_lvl", int'(done_lvl), 0);
        chk("rst_sts", int'(sts), 0);
        chk("rst_irq", int'(irq), 0);
        model_reset();
        @(negedge clk_out);
        rst_n = 1'b1;
      end
      drive_random();
      @(posedge clk_out);
      model_step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
